// File: rtl/multi_channel_cache_profiler_pkg.sv
// Shared types and helpers for the multi-channel cache profiler.
// Field and mode encodings match the software-visible readout map.
package profiler_pkg;

    localparam int FIELD_W = 2;

    typedef enum logic [FIELD_W-1:0] {
        EVENTS      = 2'd0,
        BUSY_CYC    = 2'd1,
        EPISODES    = 2'd2,
        MAX_EPISODE = 2'd3
    } field_e;

    typedef enum logic {
        MODE_EDGE  = 1'b0,
        MODE_LEVEL = 1'b1
    } mode_e;

    // Increment within a cnt_w-bit range, either sticking at all-ones or wrapping to 0.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int cnt_w,
                                            input bit saturate);
        logic [63:0] ones;
        ones = (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
        if (val != ones) return val + 64'd1;
        return saturate ? ones : '0;
    endfunction

endpackage

// File: rtl/multi_channel_cache_profiler_if.sv
// Control, event and readout bundle between the cache side and the profiler.
// The master modport belongs to whoever drives the profiler; slave is the profiler.
interface multi_channel_cache_profiler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic              enable;
    logic              clear;
    logic              snapshot;
    logic [NUM_CH-1:0] mode;
    logic [NUM_CH-1:0] event_i;
    logic [NUM_CH-1:0] busy_i;
    logic [3:0]        rd_ch;
    logic [1:0]        rd_field;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] ovf;

    modport master (
        output enable, clear, snapshot, mode, event_i, busy_i, rd_ch, rd_field,
        input  rd_data, ovf
    );

    modport slave (
        input  enable, clear, snapshot, mode, event_i, busy_i, rd_ch, rd_field,
        output rd_data, ovf
    );
endinterface

// File: rtl/multi_channel_cache_profiler_channel.sv
// One profiler channel: edge registers, four live counters, running busy length,
// sticky overflow and the four-entry snapshot bank.
module profiler_channel
    import profiler_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  snapshot,
    input  logic                  first_cyc,
    input  mode_e                 mode,
    input  logic                  event_i,
    input  logic                  busy_i,
    output logic [3:0][CNT_W-1:0] bank_o,
    output logic                  ovf_o
);

    logic                  event_q, busy_q;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d, bank_q;
    logic [CNT_W-1:0]      cur_len_q, cur_len_d;
    logic                  ovf_q, ovf_d;
    logic                  ev_hit, busy_hit, ep_hit;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(64'(v), CNT_W, SATURATE));
    endfunction

    // Edges are masked on the first cycle after reset so an input already high is not counted.
    assign ev_hit   = enable & ((mode == MODE_LEVEL) ? event_i
                                                     : (event_i & ~event_q & ~first_cyc));
    assign busy_hit = enable & busy_i;
    assign ep_hit   = busy_hit & ~busy_q & ~first_cyc;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        cnt_d     = cnt_q;
        cur_len_d = cur_len_q;
        ovf_d     = ovf_q;
        if (ev_hit) begin
            cnt_d[EVENTS] = inc(cnt_q[EVENTS]);
            ovf_d         = ovf_d | (&cnt_q[EVENTS]);
        end
        if (busy_hit) begin
            cnt_d[BUSY_CYC] = inc(cnt_q[BUSY_CYC]);
            ovf_d           = ovf_d | (&cnt_q[BUSY_CYC]);
        end
        if (ep_hit) begin
            cnt_d[EPISODES] = inc(cnt_q[EPISODES]);
            ovf_d           = ovf_d | (&cnt_q[EPISODES]);
        end
        if (!busy_i)     cur_len_d = '0;
        else if (enable) cur_len_d = inc(cur_len_q);
        // The maximum follows an episode while it is still running.
        if (cur_len_d > cnt_q[MAX_EPISODE]) cnt_d[MAX_EPISODE] = cur_len_d;
        if (clear) begin
            cnt_d     = '0;
            cur_len_d = '0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the bank is only four registers and must read 0 after reset, so it is reset too.
            event_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            cur_len_q <= '0;
            ovf_q     <= 1'b0;
            bank_q    <= '0;
        end else begin
            // NOTE: non-blocking so the bank below captures cnt_q as it stood before this edge.
            event_q   <= event_i;
            busy_q    <= busy_i;
            cnt_q     <= cnt_d;
            cur_len_q <= cur_len_d;
            ovf_q     <= ovf_d;
            if (snapshot) bank_q <= cnt_q;
        end
    end

    assign bank_o = bank_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/multi_channel_cache_profiler.sv
// Top of the multi-channel cache profiler: NUM_CH channel instances, the
// post-reset edge mask and the registered snapshot readout mux.
module multi_channel_cache_profiler
    import profiler_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input logic                          clk,
    input logic                          rst,
    multi_channel_cache_profiler_if.slave bus
);

    logic                               first_q;
    logic [NUM_CH-1:0][3:0][CNT_W-1:0]  bank;
    logic [NUM_CH-1:0]                  ovf_w;
    logic [CNT_W-1:0]                   rd_data_q, rd_data_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        profiler_channel #(
            .CNT_W   (CNT_W),
            .SATURATE(SATURATE)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .enable   (bus.enable),
            .clear    (bus.clear),
            .snapshot (bus.snapshot),
            .first_cyc(first_q),
            .mode     (mode_e'(bus.mode[g])),
            .event_i  (bus.event_i[g]),
            .busy_i   (bus.busy_i[g]),
            .bank_o   (bank[g]),
            .ovf_o    (ovf_w[g])
        );
    end

    // Unselected or out-of-range channels read as 0.
    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.rd_ch == 4'(c)) rd_data_d = bank[c][bus.rd_field];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            first_q   <= 1'b0;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.ovf     = ovf_w;

endmodule

// File: tb/tb_multi_channel_cache_profiler.sv
// Directed bench for the multi-channel cache profiler: a 32-bit main instance plus
// two 8-bit instances (saturating and wrapping) sharing the same stimulus.
module tb_multi_channel_cache_profiler;
    import profiler_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    multi_channel_cache_profiler_if #(.NUM_CH(4), .CNT_W(32)) bus ();
    multi_channel_cache_profiler_if #(.NUM_CH(4), .CNT_W(8))  if_s ();
    multi_channel_cache_profiler_if #(.NUM_CH(4), .CNT_W(8))  if_w ();

    assign if_s.enable   = bus.enable;
    assign if_s.clear    = bus.clear;
    assign if_s.snapshot = bus.snapshot;
    assign if_s.mode     = bus.mode;
    assign if_s.event_i  = bus.event_i;
    assign if_s.busy_i   = bus.busy_i;
    assign if_s.rd_ch    = bus.rd_ch;
    assign if_s.rd_field = bus.rd_field;
    assign if_w.enable   = bus.enable;
    assign if_w.clear    = bus.clear;
    assign if_w.snapshot = bus.snapshot;
    assign if_w.mode     = bus.mode;
    assign if_w.event_i  = bus.event_i;
    assign if_w.busy_i   = bus.busy_i;
    assign if_w.rd_ch    = bus.rd_ch;
    assign if_w.rd_field = bus.rd_field;

    multi_channel_cache_profiler #(.NUM_CH(4), .CNT_W(32), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    multi_channel_cache_profiler #(.NUM_CH(4), .CNT_W(8), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .bus(if_s)
    );
    multi_channel_cache_profiler #(.NUM_CH(4), .CNT_W(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .bus(if_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        bus.snapshot = 1'b1;
        tick();
        bus.snapshot = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic rd(input int ch, input field_e f);
        bus.rd_ch    = 4'(ch);
        bus.rd_field = f;
        tick();
    endtask

    initial begin
        rst          = 1'b0;
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;
        bus.snapshot = 1'b0;
        bus.mode     = '0;
        bus.event_i  = '0;
        bus.busy_i   = '0;
        bus.rd_ch    = '0;
        bus.rd_field = '0;
        #1;
        check("reset_rd_data", bus.rd_data, 0);
        check("reset_ovf", bus.ovf, 0);
        tick(); tick();
        rst        = 1'b1;
        bus.enable = 1'b1;
        tick(); tick();
        rd(0, EVENTS);
        check("reset_bank", bus.rd_data, 0);

        // Edge mode on ch0: two rising edges.
        bus.event_i[0] = 1'b1; repeat (5) tick();
        bus.event_i[0] = 1'b0; repeat (2) tick();
        bus.event_i[0] = 1'b1; repeat (3) tick();
        bus.event_i[0] = 1'b0;
        snap();
        rd(0, EVENTS);
        check("edge_events", bus.rd_data, 2);

        // Level mode, same stimulus: eight high cycles.
        do_clear();
        bus.mode[0] = 1'b1;
        bus.event_i[0] = 1'b1; repeat (5) tick();
        bus.event_i[0] = 1'b0; repeat (2) tick();
        bus.event_i[0] = 1'b1; repeat (3) tick();
        bus.event_i[0] = 1'b0;
        snap();
        rd(0, EVENTS);
        check("level_events", bus.rd_data, 8);

        // Busy windows on ch1: 4 then 7 cycles.
        bus.busy_i[1] = 1'b1; repeat (4) tick();
        bus.busy_i[1] = 1'b0; tick();
        bus.busy_i[1] = 1'b1; repeat (7) tick();
        bus.busy_i[1] = 1'b0;
        snap();
        rd(1, BUSY_CYC);
        check("busy_cyc", bus.rd_data, 11);
        rd(1, EPISODES);
        check("episodes", bus.rd_data, 2);
        bus.rd_ch    = 4'd1;
        bus.rd_field = MAX_EPISODE;
        #1;
        check("rd_latency_old", bus.rd_data, 2);
        tick();
        check("max_episode", bus.rd_data, 7);

        // 300 level events: 32-bit counts, 8-bit saturates or wraps.
        do_clear();
        bus.event_i[0] = 1'b1; repeat (300) tick();
        bus.event_i[0] = 1'b0;
        snap();
        rd(0, EVENTS);
        check("wide_events", bus.rd_data, 300);
        check("sat_events", if_s.rd_data, 255);
        check("wrap_events", if_w.rd_data, 44);
        check("wide_ovf", bus.ovf[0], 0);
        check("sat_ovf", if_s.ovf[0], 1);
        check("wrap_ovf", if_w.ovf[0], 1);

        // Atomic read-and-clear with an event in the same cycle.
        do_clear();
        check("clear_ovf_wrap", if_w.ovf, 0);
        bus.event_i[0] = 1'b1; repeat (10) tick();
        bus.snapshot = 1'b1;
        bus.clear    = 1'b1;
        tick();
        bus.snapshot   = 1'b0;
        bus.clear      = 1'b0;
        bus.event_i[0] = 1'b0;
        rd(0, EVENTS);
        check("rc_first_bank", bus.rd_data, 10);
        check("rc_ovf", bus.ovf, 0);
        snap();
        rd(0, EVENTS);
        check("rc_second_bank", bus.rd_data, 0);

        // Enable gating in edge mode.
        do_clear();
        bus.mode[0] = 1'b0;
        bus.event_i[0] = 1'b1; tick();
        bus.event_i[0] = 1'b0; tick();
        bus.enable = 1'b0;
        repeat (6) begin
            bus.event_i[0] = 1'b1; tick();
            bus.event_i[0] = 1'b0; tick();
        end
        bus.event_i[0] = 1'b1; tick();
        snap();
        rd(0, EVENTS);
        check("en_hold", bus.rd_data, 1);
        bus.enable = 1'b1;
        repeat (3) tick();
        bus.event_i[0] = 1'b0;
        snap();
        rd(0, EVENTS);
        check("en_no_false_edge", bus.rd_data, 1);
        bus.event_i[0] = 1'b1; tick();
        bus.event_i[0] = 1'b0; tick();
        snap();
        rd(0, EVENTS);
        check("en_resume", bus.rd_data, 2);
        rd(4, EVENTS);
        check("rd_ch_oob4", bus.rd_data, 0);
        rd(15, EVENTS);
        check("rd_ch_oob15", bus.rd_data, 0);

        // Reset in the middle of an episode on ch2.
        do_clear();
        bus.busy_i[2] = 1'b1; repeat (5) tick();
        snap();
        rd(2, MAX_EPISODE);
        check("pre_rst_max", bus.rd_data, 5);
        rst = 1'b0;
        #1;
        check("rst_async_rd", bus.rd_data, 0);
        tick();
        rst = 1'b1;
        rd(2, MAX_EPISODE);
        check("rst_bank_max", bus.rd_data, 0);
        rd(2, BUSY_CYC);
        check("rst_bank_busy", bus.rd_data, 0);
        rd(2, EPISODES);
        check("rst_bank_ep", bus.rd_data, 0);
        bus.busy_i[2] = 1'b0;
        snap();
        rd(2, BUSY_CYC);
        check("post_rst_busy", bus.rd_data, 3);
        rd(2, EPISODES);
        check("post_rst_no_ep", bus.rd_data, 0);
        rd(2, MAX_EPISODE);
        check("post_rst_max", bus.rd_data, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_channel_cache_profiler.md
Name: multi_channel_cache_profiler

Overview:
Parametrised successor to the fixed i/d-cache profiler. It provides NUM_CH independent event channels, and each channel carries a per-channel counting mode and a busy-window latency tracker (total cycles, episode count, longest episode). Live counters are copied atomically into a snapshot bank, and software reads that bank through a registered select/read port. The block sits beside the cache controllers and feeds the profiling CSR/AXI-lite slave.

Parameters:
NUM_CH, 4, number of channels (1..16)
CNT_W, 32, width of every counter (8..64)
SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (asserted at 0)
enable  in  1  counting enable; when low, live counters hold their value
clear  in  1  synchronous clear of all live state
snapshot  in  1  single-cycle pulse; copies live counters into the snapshot bank
mode  in  NUM_CH  per-channel mode: 0 = rising-edge count, 1 = level (cycle) count
event_i  in  NUM_CH  per-channel event strobe (e.g. miss, request, hit)
busy_i  in  NUM_CH  per-channel busy window (e.g. line fill in progress)
rd_ch  in  4  channel select for readout
rd_field  in  2  field select: 0 EVENTS, 1 BUSY_CYC, 2 EPISODES, 3 MAX_EPISODE
rd_data  out  CNT_W  selected snapshot value, registered
ovf  out  NUM_CH  sticky per-channel overflow flag (any of the four counters)

Behaviour:
- Reset (rst=0, async):
  - All live counters, snapshot bank, edge registers and ovf are 0.
  - rd_data is 0.
- Edge registers:
  - event_q and busy_q sample event_i and busy_i every cycle, independent of enable.
  - Consequence: re-enabling while an input is high does not count a false edge.
- EVENTS, edge mode: +1 when event_i & ~event_q & enable.
- EVENTS, level mode: +1 on each cycle with event_i & enable.
- Changing mode mid-run takes effect on the next cycle, with no reset of the count.
- BUSY_CYC: +1 on each cycle with busy_i & enable.
- EPISODES: +1 when busy_i & ~busy_q & enable.
- Running-length tracker (cur_len):
  - cur_len_next = cur_len+1 on a cycle with busy_i & enable.
  - cur_len_next = 0 when busy_i is low.
  - cur_len holds when enable=0 and busy_i is high.
  - cur_len is internal and never read out.
- MAX_EPISODE: updated each cycle as max(MAX_EPISODE, cur_len_next).
  - The maximum therefore tracks an in-progress episode; it does not wait for the falling edge.
- Arithmetic: all counters are unsigned, CNT_W wide.
  - On an increment at all-ones with SATURATE=1: the counter holds all-ones and ovf[ch] is set.
  - On an increment at all-ones with SATURATE=0: the counter goes to 0 and ovf[ch] is set.
  - ovf is sticky until clear or reset.
- clear (synchronous, overrides enable):
  - Next cycle: live counters, cur_len and ovf are 0.
  - The snapshot bank is untouched.
  - Events in the clear cycle are discarded.
- snapshot: the bank captures the live values as they stood before the current cycle's update.
  - snapshot together with clear acts as an atomic read-and-clear: the bank gets the pre-clear values and live state goes to 0.
  - snapshot together with an event: the event is counted in live state only and appears in the next snapshot.
- Readout: rd_data <= bank[rd_ch][rd_field], with 1-cycle latency.
  - rd_ch >= NUM_CH gives rd_data = 0.
  - A read and a snapshot in the same cycle return the old bank value.
- enable low: nothing increments, counters hold, snapshot and readout still operate.
- Reset asserted mid-episode: all state goes to 0 immediately.
  - After release, a busy_i that is already high does not count an episode, because busy_q resets to 0 and then samples high on the first active cycle.
  - BUSY_CYC still counts those cycles.
  - Note: with busy_q=0 at release the first cycle sees a rising edge. Required behaviour is that the edge registers ignore the first cycle after reset release, so both EVENTS and EPISODES suppress that edge.

Decomposition:
- Shared package profiler_pkg:
  - field_e enum (EVENTS, BUSY_CYC, EPISODES, MAX_EPISODE)
  - mode_e enum (MODE_EDGE, MODE_LEVEL)
  - FIELD_W=2
  - a sat_inc function (CNT_W, SATURATE)
- Sub-module profiler_channel, one instance per channel, generated NUM_CH times.
  - Holds the edge registers, the four live counters, cur_len, ovf and the four snapshot registers.
- Top level holds the first-cycle-after-reset flag and the registered read mux.

Test Plan:
1. Edge mode, ch0: event_i high for 5 cycles, low 2, high 3, then snapshot -> EVENTS=2. Level mode, same stimulus -> EVENTS=8.
2. busy_i on ch1 high for 4 cycles, low, then high for 7 cycles, then snapshot -> BUSY_CYC=11, EPISODES=2, MAX_EPISODE=7. Read of ch1/field 3 shows 7 one cycle after rd_* is applied.
3. CNT_W=8, SATURATE=1, level event for 300 cycles -> EVENTS=255, ovf[0]=1. With SATURATE=0 -> EVENTS=44, ovf[0]=1.
4. Count EVENTS to 10, then assert snapshot and clear together with an event in the same cycle, then snapshot again with no further events -> first bank=10, second bank=0, ovf=0.
5. enable=0 while event_i toggles 6 times -> counts unchanged. Raise enable while event_i is already high -> no increment.
6. Assert rst low mid-episode with MAX_EPISODE=5 -> rd_data=0 and all bank fields 0. rd_ch=NUM_CH -> rd_data=0.
